// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher: streams 16-bit words over adapter bursts into a
// small FIFO for decode, and redirects the fetch stream on branch.
module instr_prefetch_buffer #(
  parameter int          DEPTH     = 4,
  parameter logic [23:0] RESET_VEC = 24'h000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_branch,
  input  logic [23:0] i_branch_addr,
  output logic [15:0] o_instr,
  output logic [23:0] o_instr_addr,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [23:0] o_mem_addr,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [1:0]  o_mem_sel,
  output logic        o_mem_next,
  input  logic        i_mem_ack,
  input  logic [15:0] i_mem_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, BUS} state_t;

  state_t        state_q, state_d;
  logic [23:0]   fetch_addr_q, fetch_addr_d;
  logic [23:0]   saved_addr_q, saved_addr_d;
  logic          flush_pend_q, flush_pend_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]   data_mem_q [DEPTH];
  logic [23:0]   addr_mem_q [DEPTH];

  logic          bus_ack;
  logic          push;
  logic          pop;
  logic [CW:0]   count_inc;

  // Burst gating uses the pre-pop count so a full FIFO can never be pushed.
  assign count_inc  = {1'b0, count_q} + (CW+1)'(1);
  assign bus_ack    = (state_q == BUS) & i_mem_ack;
  assign o_mem_next = (state_q == BUS) & ~i_branch & ~flush_pend_q & (count_inc < (CW+1)'(DEPTH));
  assign o_mem_addr = (i_mem_ack & o_mem_next) ? fetch_addr_q + 24'd1 : fetch_addr_q;
  assign o_mem_req  = (state_q == BUS);
  assign o_mem_we   = 1'b0;
  assign o_mem_sel  = 2'b11;
  assign o_valid    = (count_q != '0);
  assign o_instr      = data_mem_q[rd_ptr_q];
  assign o_instr_addr = addr_mem_q[rd_ptr_q];

  // A branch flushes in the same cycle, so it cancels both the push and the pop.
  assign push = bus_ack & ~flush_pend_q & ~i_branch;
  assign pop  = o_valid & i_ready & ~i_branch;

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    saved_addr_d = saved_addr_q;
    flush_pend_d = flush_pend_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;

    case (state_q)
      IDLE: begin
        if (i_branch) begin
          fetch_addr_d = i_branch_addr;
        end else if (count_q < CW'(DEPTH)) begin
          state_d = BUS;
        end
      end
      BUS: begin
        if (i_mem_ack) begin
          fetch_addr_d = fetch_addr_q + 24'd1;
          if (i_branch) begin
            fetch_addr_d = i_branch_addr;
            flush_pend_d = 1'b0;
            state_d      = IDLE;
          end else if (flush_pend_q) begin
            fetch_addr_d = saved_addr_q;
            flush_pend_d = 1'b0;
            state_d      = IDLE;
          end else if (!o_mem_next) begin
            state_d = IDLE;
          end
        end else if (i_branch) begin
          flush_pend_d = 1'b1;
          saved_addr_d = i_branch_addr;
        end
      end
      default: state_d = IDLE;
    endcase

    if (i_branch) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      fetch_addr_q <= RESET_VEC;
      flush_pend_q <= 1'b0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      flush_pend_q <= flush_pend_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Storage carries no reset; o_valid qualifies everything read from it.
  always_ff @(posedge i_clk) begin
    saved_addr_q <= saved_addr_d;
    if (push) begin
      data_mem_q[wr_ptr_q] <= i_mem_data;
      addr_mem_q[wr_ptr_q] <= fetch_addr_q;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer: cycle table for the main instance plus a
// short wrap-around sequence on a second instance reset near the top of the address space.
module tb_instr_prefetch_buffer;

  logic        clk = 1'b0;
  logic        rst, br, rdy, ack;
  logic [23:0] baddr;
  logic [15:0] dat;

  logic [15:0] instr1, instr2;
  logic [23:0] iaddr1, iaddr2, maddr1, maddr2;
  logic        vld1, vld2, req1, req2, we1, we2, nxt1, nxt2;
  logic [1:0]  sel1, sel2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_prefetch_buffer #(.DEPTH(4), .RESET_VEC(24'h000000)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_branch(br), .i_branch_addr(baddr),
    .o_instr(instr1), .o_instr_addr(iaddr1), .o_valid(vld1), .i_ready(rdy),
    .o_mem_addr(maddr1), .o_mem_req(req1), .o_mem_we(we1), .o_mem_sel(sel1),
    .o_mem_next(nxt1), .i_mem_ack(ack), .i_mem_data(dat)
  );

  instr_prefetch_buffer #(.DEPTH(4), .RESET_VEC(24'hFFFFFE)) u_dut_wrap (
    .i_clk(clk), .i_rst(rst), .i_branch(br), .i_branch_addr(baddr),
    .o_instr(instr2), .o_instr_addr(iaddr2), .o_valid(vld2), .i_ready(rdy),
    .o_mem_addr(maddr2), .o_mem_req(req2), .o_mem_we(we2), .o_mem_sel(sel2),
    .o_mem_next(nxt2), .i_mem_ack(ack), .i_mem_data(dat)
  );

  typedef struct packed {
    logic        rst;
    logic        br;
    logic [23:0] baddr;
    logic        rdy;
    logic        ack;
    logic [15:0] dat;
    logic        req;
    logic        nxt;
    logic [23:0] maddr;
    logic        vld;
    logic [23:0] iaddr;
    logic [15:0] instr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic b, logic [23:0] ba, logic rd, logic a, logic [15:0] d,
                              logic q, logic n, logic [23:0] ma, logic v, logic [23:0] ia,
                              logic [15:0] ins);
    vec_t t;
    t.rst = r; t.br = b; t.baddr = ba; t.rdy = rd; t.ack = a; t.dat = d;
    t.req = q; t.nxt = n; t.maddr = ma; t.vld = v; t.iaddr = ia; t.instr = ins;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic b, input logic [23:0] ba, input logic rd,
                       input logic a, input logic [15:0] d);
    @(negedge clk);
    rst = r; br = b; baddr = ba; rdy = rd; ack = a; dat = d;
    #2;
  endtask

  task automatic reset_both();
    drive(1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 16'h0);
    drive(1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    rst = 1'b1; br = 1'b0; baddr = '0; rdy = 1'b0; ack = 1'b0; dat = '0;

    //             rst br baddr     rdy ack dat       req nxt maddr     vld iaddr     instr
    // reset state and first fetch, sparse acks
    tbl.push_back(mk(0, 0, 24'h0,   1, 0, 16'h0,     0, 0, 24'h000000, 0, 24'h0,   16'h0));
    tbl.push_back(mk(0, 0, 24'h0,   1, 0, 16'h0,     1, 1, 24'h000000, 0, 24'h0,   16'h0));
    tbl.push_back(mk(0, 0, 24'h0,   1, 1, 16'h1000,  1, 1, 24'h000001, 0, 24'h0,   16'h0));
    tbl.push_back(mk(0, 0, 24'h0,   1, 0, 16'h0,     1, 1, 24'h000001, 1, 24'h0,   16'h1000));
    // continuous stream with consumer ready
    tbl.push_back(mk(0, 0, 24'h0,   1, 1, 16'h1001,  1, 1, 24'h000002, 0, 24'h0,   16'h0));
    tbl.push_back(mk(0, 0, 24'h0,   1, 1, 16'h1002,  1, 1, 24'h000003, 1, 24'h1,   16'h1001));
    tbl.push_back(mk(0, 0, 24'h0,   1, 1, 16'h1003,  1, 1, 24'h000004, 1, 24'h2,   16'h1002));
    tbl.push_back(mk(0, 0, 24'h0,   1, 0, 16'h0,     1, 1, 24'h000004, 1, 24'h3,   16'h1003));
    // consumer stalled: fill to DEPTH, next drops on 4th ack, req drops
    tbl.push_back(mk(0, 0, 24'h0,   0, 1, 16'h2004,  1, 1, 24'h000005, 0, 24'h0,   16'h0));
    tbl.push_back(mk(0, 0, 24'h0,   0, 1, 16'h2005,  1, 1, 24'h000006, 1, 24'h4,   16'h2004));
    tbl.push_back(mk(0, 0, 24'h0,   0, 1, 16'h2006,  1, 1, 24'h000007, 1, 24'h4,   16'h2004));
    tbl.push_back(mk(0, 0, 24'h0,   0, 1, 16'h2007,  1, 0, 24'h000007, 1, 24'h4,   16'h2004));
    tbl.push_back(mk(0, 0, 24'h0,   0, 0, 16'h0,     0, 0, 24'h000008, 1, 24'h4,   16'h2004));
    tbl.push_back(mk(0, 0, 24'h0,   0, 0, 16'h0,     0, 0, 24'h000008, 1, 24'h4,   16'h2004));
    tbl.push_back(mk(0, 0, 24'h0,   1, 0, 16'h0,     0, 0, 24'h000008, 1, 24'h4,   16'h2004));
    tbl.push_back(mk(0, 0, 24'h0,   0, 0, 16'h0,     0, 0, 24'h000008, 1, 24'h5,   16'h2005));
    tbl.push_back(mk(0, 0, 24'h0,   0, 0, 16'h0,     1, 0, 24'h000008, 1, 24'h5,   16'h2005));
    // branch while request pending: flush, drop next ack, one idle cycle
    tbl.push_back(mk(0, 1, 24'h100, 1, 0, 16'h0,     1, 0, 24'h000008, 1, 24'h5,   16'h2005));
    tbl.push_back(mk(0, 0, 24'h0,   1, 0, 16'h0,     1, 0, 24'h000008, 0, 24'h0,   16'h0));
    tbl.push_back(mk(0, 0, 24'h0,   1, 1, 16'hDEAD,  1, 0, 24'h000008, 0, 24'h0,   16'h0));
    tbl.push_back(mk(0, 0, 24'h0,   1, 0, 16'h0,     0, 0, 24'h000100, 0, 24'h0,   16'h0));
    tbl.push_back(mk(0, 0, 24'h0,   1, 0, 16'h0,     1, 1, 24'h000100, 0, 24'h0,   16'h0));
    // branch coinciding with ack
    tbl.push_back(mk(0, 1, 24'h200, 1, 1, 16'hBEEF,  1, 0, 24'h000100, 0, 24'h0,   16'h0));
    tbl.push_back(mk(0, 0, 24'h0,   1, 0, 16'h0,     0, 0, 24'h000200, 0, 24'h0,   16'h0));
    tbl.push_back(mk(0, 0, 24'h0,   1, 1, 16'h3200,  1, 1, 24'h000201, 0, 24'h0,   16'h0));
    tbl.push_back(mk(0, 0, 24'h0,   1, 0, 16'h0,     1, 1, 24'h000201, 1, 24'h200, 16'h3200));
    // two branches while pending: the later target wins
    tbl.push_back(mk(0, 1, 24'h300, 1, 0, 16'h0,     1, 0, 24'h000201, 0, 24'h0,   16'h0));
    tbl.push_back(mk(0, 1, 24'h400, 1, 0, 16'h0,     1, 0, 24'h000201, 0, 24'h0,   16'h0));
    tbl.push_back(mk(0, 0, 24'h0,   1, 1, 16'hDEAD,  1, 0, 24'h000201, 0, 24'h0,   16'h0));
    // branch while idle retargets without starting a burst that cycle
    tbl.push_back(mk(0, 1, 24'h600, 1, 0, 16'h0,     0, 0, 24'h000400, 0, 24'h0,   16'h0));
    tbl.push_back(mk(0, 0, 24'h0,   1, 0, 16'h0,     0, 0, 24'h000600, 0, 24'h0,   16'h0));
    tbl.push_back(mk(0, 0, 24'h0,   0, 0, 16'h0,     1, 1, 24'h000600, 0, 24'h0,   16'h0));
    tbl.push_back(mk(0, 0, 24'h0,   0, 1, 16'h4600,  1, 1, 24'h000601, 0, 24'h0,   16'h0));
    // reset mid-burst, stray ack afterwards ignored, restart at reset vector
    tbl.push_back(mk(1, 0, 24'h0,   0, 0, 16'h0,     1, 1, 24'h000601, 1, 24'h600, 16'h4600));
    tbl.push_back(mk(0, 0, 24'h0,   0, 1, 16'hDEAD,  0, 0, 24'h000000, 0, 24'h0,   16'h0));
    tbl.push_back(mk(0, 0, 24'h0,   0, 0, 16'h0,     1, 1, 24'h000000, 0, 24'h0,   16'h0));
    tbl.push_back(mk(0, 0, 24'h0,   0, 1, 16'h5000,  1, 1, 24'h000001, 0, 24'h0,   16'h0));
    tbl.push_back(mk(0, 0, 24'h0,   1, 0, 16'h0,     1, 1, 24'h000001, 1, 24'h0,   16'h5000));

    reset_both();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].br, tbl[i].baddr, tbl[i].rdy, tbl[i].ack, tbl[i].dat);
      check($sformatf("row%0d req", i),   32'(req1),   32'(tbl[i].req));
      check($sformatf("row%0d next", i),  32'(nxt1),   32'(tbl[i].nxt));
      check($sformatf("row%0d maddr", i), 32'(maddr1), 32'(tbl[i].maddr));
      check($sformatf("row%0d valid", i), 32'(vld1),   32'(tbl[i].vld));
      if (tbl[i].vld) begin
        check($sformatf("row%0d iaddr", i), 32'(iaddr1), 32'(tbl[i].iaddr));
        check($sformatf("row%0d instr", i), 32'(instr1), 32'(tbl[i].instr));
      end
      check($sformatf("row%0d we", i),  32'(we1),  32'h0);
      check($sformatf("row%0d sel", i), 32'(sel1), 32'h3);
    end

    // address wrap from a reset vector near 0xFFFFFF
    reset_both();
    drive(1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 16'h0);
    check("wrap idle req",   32'(req2),   32'h0);
    check("wrap idle maddr", 32'(maddr2), 32'hFFFFFE);
    drive(1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 16'h0);
    check("wrap req",        32'(req2),   32'h1);
    check("wrap maddr0",     32'(maddr2), 32'hFFFFFE);
    drive(1'b0, 1'b0, 24'h0, 1'b1, 1'b1, 16'h000A);
    check("wrap maddr1",     32'(maddr2), 32'hFFFFFF);
    drive(1'b0, 1'b0, 24'h0, 1'b1, 1'b1, 16'h000B);
    check("wrap maddr2",     32'(maddr2), 32'h000000);
    check("wrap iaddr0",     32'(iaddr2), 32'hFFFFFE);
    check("wrap instr0",     32'(instr2), 32'h000A);
    drive(1'b0, 1'b0, 24'h0, 1'b1, 1'b1, 16'h000C);
    check("wrap maddr3",     32'(maddr2), 32'h000001);
    check("wrap iaddr1",     32'(iaddr2), 32'hFFFFFF);
    check("wrap instr1",     32'(instr2), 32'h000B);
    drive(1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 16'h0);
    check("wrap valid2",     32'(vld2),   32'h1);
    check("wrap iaddr2",     32'(iaddr2), 32'h000000);
    check("wrap instr2",     32'(instr2), 32'h000C);
    check("wrap maddr4",     32'(maddr2), 32'h000001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
